// File: rtl/decode_stage_pipe.sv
// Buffered RV32I decode stage: instruction FIFO feeding a registered decode slot.
// Optional RV32M recognition is enabled by defining DECODE_M_EXT_EN.
module decode_stage_pipe #(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned XLEN      = 32,
    localparam int unsigned CNT_W    = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic [6:0]       opcode_o,
    output logic [2:0]       func3_o,
    output logic [6:0]       func7_o,
    output logic [XLEN-1:0]  immed_o,
    output logic             i_en_o,
    output logic             r_en_o,
    output logic             s_en_o,
    output logic             sb_en_o,
    output logic             u_en_o,
    output logic             uj_en_o,
    output logic             m_en_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] immed;
        logic            i_en;
        logic            r_en;
        logic            s_en;
        logic            sb_en;
        logic            u_en;
        logic            uj_en;
        logic            m_en;
        logic            illegal;
    } dec_t;

    logic [31:0]      mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             out_valid;
    dec_t             out_q;
    dec_t             dec;
    logic [31:0]      head;
    logic signed [31:0] imm32;
    logic             push;
    logic             load;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends on occupancy only, so there is no path from out_ready_i.
    assign in_ready_o = (count < DEPTH_CNT);
    assign push       = in_valid_i & in_ready_o & ~flush_i;
    assign load       = (count != '0) & (~out_valid | out_ready_i) & ~flush_i;
    assign head       = mem[rd_ptr];

    // Combinational decode of the FIFO head.
    always_comb begin
        dec         = '0;
        imm32       = '0;
        dec.rs1     = head[19:15];
        dec.rs2     = head[24:20];
        dec.rd      = head[11:7];
        dec.opcode  = head[6:0];
        dec.func3   = head[14:12];
        dec.func7   = head[31:25];
        dec.illegal = 1'b1;
        if (head[1:0] == 2'b11) begin
            case (head[6:0])
                OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                    dec.i_en    = 1'b1;
                    dec.illegal = 1'b0;
                    imm32       = 32'($signed(head[31:20]));
                end
                OPC_STORE: begin
                    dec.s_en    = 1'b1;
                    dec.illegal = 1'b0;
                    imm32       = 32'($signed({head[31:25], head[11:7]}));
                end
                OPC_BRANCH: begin
                    dec.sb_en   = 1'b1;
                    dec.illegal = 1'b0;
                    imm32       = 32'($signed({head[31], head[7], head[30:25],
                                               head[11:8], 1'b0}));
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec.u_en    = 1'b1;
                    dec.illegal = 1'b0;
                    imm32       = $signed({head[31:12], 12'b0});
                end
                OPC_JAL: begin
                    dec.uj_en   = 1'b1;
                    dec.illegal = 1'b0;
                    imm32       = 32'($signed({head[31], head[19:12], head[20],
                                               head[30:21], 1'b0}));
                end
                OPC_OP: begin
                    if (head[31:25] == 7'b0000000 || head[31:25] == 7'b0100000) begin
                        dec.r_en    = 1'b1;
                        dec.illegal = 1'b0;
                    end
`ifdef DECODE_M_EXT_EN
                    else if (head[31:25] == 7'b0000001) begin
                        dec.m_en    = 1'b1;
                        dec.illegal = 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
        dec.immed = XLEN'(imm32);
    end

    // FIFO storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= instr_i;
        end
    end

    // Pointers, occupancy and output slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (flush_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (load) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, load})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            if (load) begin
                out_valid <= 1'b1;
                out_q     <= dec;
            end else if (out_ready_i) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid;
    assign count_o     = count;
    assign rs1_o       = out_q.rs1;
    assign rs2_o       = out_q.rs2;
    assign rd_o        = out_q.rd;
    assign opcode_o    = out_q.opcode;
    assign func3_o     = out_q.func3;
    assign func7_o     = out_q.func7;
    assign immed_o     = out_q.immed;
    assign i_en_o      = out_q.i_en;
    assign r_en_o      = out_q.r_en;
    assign s_en_o      = out_q.s_en;
    assign sb_en_o     = out_q.sb_en;
    assign u_en_o      = out_q.u_en;
    assign uj_en_o     = out_q.uj_en;
    assign m_en_o      = out_q.m_en;
    assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe (BUF_DEPTH=2, XLEN=32).
module tb_decode_stage_pipe;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       rs1, rs2, rd;
    logic [6:0]       opcode, func7;
    logic [2:0]       func3;
    logic [XLEN-1:0]  immed;
    logic             i_en, r_en, s_en, sb_en, u_en, uj_en, m_en, illegal;
    logic [CNT_W-1:0] count;
    logic [7:0]       en;

    int checks   = 0;
    int failures = 0;

    assign en = {i_en, r_en, s_en, sb_en, u_en, uj_en, m_en, illegal};

    decode_stage_pipe #(.BUF_DEPTH(BUF_DEPTH), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .instr_i(instr),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .opcode_o(opcode),
        .func3_o(func3), .func7_o(func7), .immed_o(immed),
        .i_en_o(i_en), .r_en_o(r_en), .s_en_o(s_en), .sb_en_o(sb_en),
        .u_en_o(u_en), .uj_en_o(uj_en), .m_en_o(m_en), .illegal_o(illegal),
        .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction with the slot empty and out_ready low; it lands in the slot.
    task automatic push_one(input logic [31:0] ins);
        in_valid = 1'b1;
        instr    = ins;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Three pushes with out_ready low: A in the slot, B and C in the FIFO.
    task automatic fill_three();
        in_valid = 1'b1;
        instr = 32'h00100093; step();
        instr = 32'h00200113; step();
        instr = 32'h00300193; step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        repeat (2) step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (en !== 8'h00 || immed !== 32'h0) begin failures++; $display("FAIL reset_fields en=%b immed=%h exp=0", en, immed); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_latency_i_type();
        in_valid = 1'b1;
        instr    = 32'h00600293;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 2'd1) begin failures++; $display("FAIL lat_edge1 valid=%b count=%0d exp valid=0 count=1", out_valid, count); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_edge2 valid=%b exp=1", out_valid); end
        checks++; if (en !== 8'b1000_0000) begin failures++; $display("FAIL i_en got=%b exp=10000000", en); end
        checks++; if (rd !== 5'd5 || rs1 !== 5'd0 || opcode !== 7'h13) begin failures++; $display("FAIL i_fields rd=%0d rs1=%0d op=%h exp 5 0 13", rd, rs1, opcode); end
        checks++; if (immed !== 32'h6) begin failures++; $display("FAIL i_immed got=%h exp=00000006", immed); end
        drain();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_r_type();
        push_one(32'h007372B3);
        checks++; if (en !== 8'b0100_0000) begin failures++; $display("FAIL r_en got=%b exp=01000000", en); end
        checks++; if (rs1 !== 5'd6 || rs2 !== 5'd7 || rd !== 5'd5) begin failures++; $display("FAIL r_regs rs1=%0d rs2=%0d rd=%0d exp 6 7 5", rs1, rs2, rd); end
        checks++; if (func3 !== 3'h7 || func7 !== 7'h00 || immed !== 32'h0) begin failures++; $display("FAIL r_func f3=%h f7=%h imm=%h exp 7 0 0", func3, func7, immed); end
        drain();
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [7:0]  en;
        logic [31:0] imm;
        logic [4:0]  rd;
    } vec_t;

    task automatic test_decode_table();
        vec_t v [12];
        v[0]  = '{32'h40135293, 8'b1000_0000, 32'h00000401, 5'd5};
        v[1]  = '{32'hFFF00293, 8'b1000_0000, 32'hFFFFFFFF, 5'd5};
        v[2]  = '{32'hFE532E23, 8'b0010_0000, 32'hFFFFFFFC, 5'd28};
        v[3]  = '{32'hFE0018E3, 8'b0001_0000, 32'hFFFFFFF0, 5'd17};
        v[4]  = '{32'h800002B7, 8'b0000_1000, 32'h80000000, 5'd5};
        v[5]  = '{32'hFFDFF0EF, 8'b0000_0100, 32'hFFFFFFFC, 5'd1};
        v[6]  = '{32'h00000000, 8'b0000_0001, 32'h00000000, 5'd0};
        v[7]  = '{32'h04000033, 8'b0000_0001, 32'h00000000, 5'd0};
`ifdef DECODE_M_EXT_EN
        v[8]  = '{32'h02A30333, 8'b0000_0010, 32'h00000000, 5'd6};
`else
        v[8]  = '{32'h02A30333, 8'b0000_0001, 32'h00000000, 5'd6};
`endif
        v[9]  = '{32'h00100073, 8'b1000_0000, 32'h00000001, 5'd0};
        v[10] = '{32'hFFFFFFFF, 8'b0000_0001, 32'h00000000, 5'd31};
        v[11] = '{32'h00C58513, 8'b1000_0000, 32'h0000000C, 5'd10};
        for (int i = 0; i < 12; i++) begin
            push_one(v[i].ins);
            checks++; if (en !== v[i].en) begin failures++; $display("FAIL tbl%0d_en instr=%h got=%b exp=%b", i, v[i].ins, en, v[i].en); end
            checks++; if (immed !== v[i].imm) begin failures++; $display("FAIL tbl%0d_immed instr=%h got=%h exp=%h", i, v[i].ins, immed, v[i].imm); end
            checks++; if (rd !== v[i].rd) begin failures++; $display("FAIL tbl%0d_rd instr=%h got=%0d exp=%0d", i, v[i].ins, rd, v[i].rd); end
            drain();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr = 32'h00100093; step();
        checks++; if (out_valid !== 1'b0 || count !== 2'd1) begin failures++; $display("FAIL b2b_e1 valid=%b count=%0d exp 0 1", out_valid, count); end
        instr = 32'h00200113; step();
        checks++; if (out_valid !== 1'b1 || rd !== 5'd1 || count !== 2'd1) begin failures++; $display("FAIL b2b_e2 valid=%b rd=%0d count=%0d exp 1 1 1", out_valid, rd, count); end
        instr = 32'h00300193; step();
        checks++; if (out_valid !== 1'b1 || rd !== 5'd2 || count !== 2'd1) begin failures++; $display("FAIL b2b_e3 valid=%b rd=%0d count=%0d exp 1 2 1", out_valid, rd, count); end
        in_valid = 1'b0; step();
        checks++; if (out_valid !== 1'b1 || rd !== 5'd3 || immed !== 32'h3 || count !== 2'd0) begin failures++; $display("FAIL b2b_e4 valid=%b rd=%0d imm=%h count=%0d exp 1 3 3 0", out_valid, rd, immed, count); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_e5 valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_three();
        checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_full count=%0d ready=%b exp 2 0", count, in_ready); end
        checks++; if (out_valid !== 1'b1 || rd !== 5'd1) begin failures++; $display("FAIL bp_slot valid=%b rd=%0d exp 1 1", out_valid, rd); end
        step();
        checks++; if (rd !== 5'd1 || immed !== 32'h1 || count !== 2'd2) begin failures++; $display("FAIL bp_hold rd=%0d imm=%h count=%0d exp 1 1 2", rd, immed, count); end
        // Pop while full with a push offered: the push must be refused.
        in_valid = 1'b1; instr = 32'h00400213; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (rd !== 5'd2 || count !== 2'd1) begin failures++; $display("FAIL bp_pop1 rd=%0d count=%0d exp 2 1", rd, count); end
        step();
        checks++; if (out_valid !== 1'b1 || rd !== 5'd3 || count !== 2'd0) begin failures++; $display("FAIL bp_pop2 valid=%b rd=%0d count=%0d exp 1 3 0", out_valid, rd, count); end
        step();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL bp_nopush valid=%b count=%0d exp 0 0", out_valid, count); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        fill_three();
        flush = 1'b1; in_valid = 1'b1; instr = 32'h00400213;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush count=%0d valid=%b ready=%b exp 0 0 1", count, out_valid, in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL flush_lost valid=%b count=%0d exp 0 0", out_valid, count); end
        out_ready = 1'b0;
        push_one(32'h00500293);
        checks++; if (out_valid !== 1'b1 || rd !== 5'd5 || immed !== 32'h5) begin failures++; $display("FAIL flush_after valid=%b rd=%0d imm=%h exp 1 5 5", out_valid, rd, immed); end
        drain();
    endtask

    task automatic test_async_reset();
        fill_three();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_ctrl valid=%b count=%0d ready=%b exp 0 0 1", out_valid, count, in_ready); end
        checks++; if (rd !== 5'd0 || immed !== 32'h0 || en !== 8'h00) begin failures++; $display("FAIL arst_fields rd=%0d imm=%h en=%b exp 0", rd, immed, en); end
        step();
        rst_n = 1'b1;
        step();
        push_one(32'h00700393);
        checks++; if (out_valid !== 1'b1 || rd !== 5'd7 || immed !== 32'h7) begin failures++; $display("FAIL arst_after valid=%b rd=%0d imm=%h exp 1 7 7", out_valid, rd, immed); end
        drain();
    endtask

    initial begin
        test_reset();
        test_latency_i_type();
        test_r_type();
        test_decode_table();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
